mem_read_arbiter: RTL and testbench
===================================

MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- NB_ADDRESS, 10, memory address width.
- BITS_DATA, 13, width of one memory word.
- N_MEM, 4, number of memory blocks sharing one read address.
- STARVE_MAX, 8, host wait cycles before a forced host grant.
REQ-002 Ports (name, direction, width, meaning), one per line:
- i_CLK, in, 1, single clock; all state updates on the rising edge.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_run_req, in, 1, run-engine read request (level).
- i_run_raddr, in, NB_ADDRESS, run-engine read address.
- o_run_gnt, out, 1, run request accepted this cycle.
- o_run_rvalid, out, 1, o_run_rdata valid.
- o_run_rdata, out, N_MEM*BITS_DATA, all blocks' words for the run engine.
- i_host_req, in, 1, host readback request (level).
- i_host_raddr, in, NB_ADDRESS, host read address.
- i_host_blk, in, clog2(N_MEM), host block select.
- o_host_gnt, out, 1, host request accepted this cycle.
- o_host_rvalid, out, 1, o_host_rdata valid.
- o_host_rdata, out, BITS_DATA, selected block word.
- o_mem_raddr, out, NB_ADDRESS, registered shared read address to all memories.
- i_mem_rdata, in, N_MEM*BITS_DATA, concatenated synchronous-read outputs (1-cycle latency).
- o_busy, out, 1, a read is in flight.

Function
REQ-003 A transfer occurs in cycle t when req and gnt are both high; o_run_gnt and o_host_gnt are combinational from the requests and registered arbiter state, and never both high.
REQ-004 Arbiter states: PRI_RUN (default) and FORCE_HOST.
REQ-005 In PRI_RUN, a run request wins; the host is granted only when i_run_req is low.
REQ-006 In FORCE_HOST, the host is granted if i_host_req is high, and the run engine is granted otherwise.
REQ-007 The starve counter (width clog2(STARVE_MAX+1)) increments each cycle i_host_req is high and o_host_gnt is low; it clears whenever o_host_gnt is high or i_host_req is low.
REQ-008 When the starve counter equals STARVE_MAX, the state for the next cycle is FORCE_HOST; FORCE_HOST lasts exactly one cycle, then the state returns to PRI_RUN.
REQ-009 At t+1, o_mem_raddr holds the granted address; with no grant at t, o_mem_raddr holds its previous value.
REQ-010 At t+2, the granted requester's rvalid is high for one cycle, and its data comes from i_mem_rdata.
REQ-011 o_run_rdata carries i_mem_rdata unchanged.
REQ-012 o_host_rdata is the i_mem_rdata slice selected by i_host_blk captured at t (pipelined two stages); an out-of-range block index returns 0.
REQ-013 Back-to-back grants are supported at one per cycle with full throughput; owner and block tags are pipelined per transfer.
REQ-014 o_busy is high when a stage-1 or stage-2 tag is valid.
REQ-015 rdata outputs are registered and hold their value when rvalid is low.
REQ-016 A request withdrawn before grant causes no transfer; address and block inputs are sampled only in the grant cycle.

Reset
REQ-017 Asserting i_rst_n low asynchronously forces the following: state PRI_RUN; counter 0; gnt-enabling state cleared; o_run_rvalid, o_host_rvalid and o_busy 0; o_mem_raddr, o_run_rdata and o_host_rdata 0.
REQ-018 Reset mid-operation discards in-flight reads: no rvalid is issued for transfers granted before reset.
REQ-019 Grants resume in the first clock cycle after i_rst_n deasserts.

Verification
REQ-020 Run-only stream: run_req high with addresses 0..5 -> gnt high on every cycle; o_mem_raddr shows 0..5 one cycle later; run_rvalid high on 6 consecutive cycles starting at t+2, with matching data.
REQ-021 Host-only read: addr 0x3A, blk 2 -> host_gnt at t; host_rvalid at t+2; o_host_rdata equals i_mem_rdata[3*BITS_DATA-1:2*BITS_DATA].
REQ-022 Starvation: run_req and host_req both held high -> host_gnt exactly once every STARVE_MAX+1 cycles (cycle 9, 18, ... with default 8); run_gnt low only in those cycles.
REQ-023 Simultaneous requests with the counter below the limit -> run granted, host not granted, counter increments.
REQ-024 Reset mid-flight: grant at t, i_rst_n low at t+1 -> no rvalid at t+2; all outputs 0; the first grant after release is served normally.
REQ-025 Invalid block: host blk 3 with N_MEM=3 -> host_rvalid high and o_host_rdata 0.

Source files
------------

// File: rtl/mem_read_arbiter.sv
// Two-requester read arbiter in front of N_MEM memory blocks that share one read address.
// The run engine has priority; a starve counter forces a single host grant after STARVE_MAX waits.
module mem_read_arbiter #(
    parameter  int NB_ADDRESS = 10,
    parameter  int BITS_DATA  = 13,
    parameter  int N_MEM      = 4,
    parameter  int STARVE_MAX = 8,
    localparam int NB_BLK     = (N_MEM > 1) ? $clog2(N_MEM) : 1,
    localparam int NB_STARVE  = $clog2(STARVE_MAX + 1)
) (
    input  logic                       i_CLK,
    input  logic                       i_rst_n,
    input  logic                       i_run_req,
    input  logic [NB_ADDRESS-1:0]      i_run_raddr,
    output logic                       o_run_gnt,
    output logic                       o_run_rvalid,
    output logic [N_MEM*BITS_DATA-1:0] o_run_rdata,
    input  logic                       i_host_req,
    input  logic [NB_ADDRESS-1:0]      i_host_raddr,
    input  logic [NB_BLK-1:0]          i_host_blk,
    output logic                       o_host_gnt,
    output logic                       o_host_rvalid,
    output logic [BITS_DATA-1:0]       o_host_rdata,
    output logic [NB_ADDRESS-1:0]      o_mem_raddr,
    input  logic [N_MEM*BITS_DATA-1:0] i_mem_rdata,
    output logic                       o_busy
);

    typedef enum logic {
        PRI_RUN    = 1'b0,
        FORCE_HOST = 1'b1
    } arb_state_e;

    localparam logic [NB_STARVE-1:0] STARVE_LIM = NB_STARVE'(STARVE_MAX);

    arb_state_e           state_q, state_d;
    logic [NB_STARVE-1:0] starve_q, starve_d;

    logic                 s1_valid, s1_host;
    logic [NB_BLK-1:0]    s1_blk;
    logic [BITS_DATA-1:0] host_word;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        o_run_gnt  = 1'b0;
        o_host_gnt = 1'b0;
        if (i_rst_n) begin
            case (state_q)
                FORCE_HOST: begin
                    o_host_gnt = i_host_req;
                    o_run_gnt  = i_run_req && !i_host_req;
                end
                default: begin
                    o_run_gnt  = i_run_req;
                    o_host_gnt = i_host_req && !i_run_req;
                end
            endcase
        end
        starve_d = (i_host_req && !o_host_gnt) ? starve_q + NB_STARVE'(1) : '0;
        // The force state is entered on the same edge the counter reaches the limit, so it lasts one cycle.
        state_d  = (starve_d == STARVE_LIM) ? FORCE_HOST : PRI_RUN;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_CLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= PRI_RUN;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Stage 1: shared address register plus owner/block tag of the granted transfer.
    always_ff @(posedge i_CLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_mem_raddr <= '0;
            s1_valid    <= 1'b0;
            s1_host     <= 1'b0;
            s1_blk      <= '0;
        end else begin
            s1_valid <= o_run_gnt || o_host_gnt;
            s1_host  <= o_host_gnt;
            if (o_host_gnt) begin
                o_mem_raddr <= i_host_raddr;
                s1_blk      <= i_host_blk;
            end else if (o_run_gnt) begin
                o_mem_raddr <= i_run_raddr;
            end
        end
    end

    always_comb begin
        host_word = '0;
        for (int i = 0; i < N_MEM; i++) begin
            if (int'(s1_blk) == i) begin
                host_word = i_mem_rdata[i*BITS_DATA +: BITS_DATA];
            end
        end
    end

    // Stage 2: registered read data, updated only for its own owner so it holds otherwise.
    always_ff @(posedge i_CLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_run_rvalid  <= 1'b0;
            o_host_rvalid <= 1'b0;
            o_run_rdata   <= '0;
            o_host_rdata  <= '0;
        end else begin
            o_run_rvalid  <= s1_valid && !s1_host;
            o_host_rvalid <= s1_valid && s1_host;
            if (s1_valid && !s1_host) begin
                o_run_rdata <= i_mem_rdata;
            end
            if (s1_valid && s1_host) begin
                o_host_rdata <= host_word;
            end
        end
    end

    assign o_busy = s1_valid || o_run_rvalid || o_host_rvalid;

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Randomized scoreboard bench for mem_read_arbiter (N_MEM=3 so an invalid block index exists).
// A driver predicts grants and pushes expected reads; a negedge monitor pops and compares.
module tb_mem_read_arbiter;

    localparam int NA = 10;
    localparam int BD = 13;
    localparam int NM = 3;
    localparam int SM = 8;

    logic              i_CLK = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_run_req = 1'b0;
    logic [NA-1:0]     i_run_raddr = '0;
    logic              o_run_gnt, o_run_rvalid;
    logic [NM*BD-1:0]  o_run_rdata;
    logic              i_host_req = 1'b0;
    logic [NA-1:0]     i_host_raddr = '0;
    logic [1:0]        i_host_blk = '0;
    logic              o_host_gnt, o_host_rvalid;
    logic [BD-1:0]     o_host_rdata;
    logic [NA-1:0]     o_mem_raddr;
    logic [NM*BD-1:0]  i_mem_rdata;
    logic              o_busy;

    mem_read_arbiter #(
        .NB_ADDRESS(NA), .BITS_DATA(BD), .N_MEM(NM), .STARVE_MAX(SM)
    ) dut (
        .i_CLK        (i_CLK),
        .i_rst_n      (i_rst_n),
        .i_run_req    (i_run_req),
        .i_run_raddr  (i_run_raddr),
        .o_run_gnt    (o_run_gnt),
        .o_run_rvalid (o_run_rvalid),
        .o_run_rdata  (o_run_rdata),
        .i_host_req   (i_host_req),
        .i_host_raddr (i_host_raddr),
        .i_host_blk   (i_host_blk),
        .o_host_gnt   (o_host_gnt),
        .o_host_rvalid(o_host_rvalid),
        .o_host_rdata (o_host_rdata),
        .o_mem_raddr  (o_mem_raddr),
        .i_mem_rdata  (i_mem_rdata),
        .o_busy       (o_busy)
    );

    always #5 i_CLK = ~i_CLK;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge i_CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents: a fixed hash of address and block; read data follows the registered address.
    function automatic logic [BD-1:0] mem_word(input logic [NA-1:0] a, input int b);
        return BD'((int'(a) * 37) ^ (b * 1111) ^ 165);
    endfunction

    function automatic logic [NM*BD-1:0] run_word(input logic [NA-1:0] a);
        logic [NM*BD-1:0] w;
        for (int b = 0; b < NM; b++) w[b*BD +: BD] = mem_word(a, b);
        return w;
    endfunction

    always_comb begin
        i_mem_rdata = '0;
        for (int b = 0; b < NM; b++) i_mem_rdata[b*BD +: BD] = mem_word(o_mem_raddr, b);
    end

    typedef struct {
        logic             is_host;
        logic [NM*BD-1:0] data;
        int               due;
    } exp_t;

    exp_t             sb[$];
    int               wait_cnt = 0;
    logic [NA-1:0]    model_raddr = '0;
    logic [NM*BD-1:0] last_run = '0;
    logic [BD-1:0]    last_host = '0;

    // One cycle of stimulus: the host wins if it has waited STARVE_MAX cycles or the run engine is idle.
    task automatic drive(input logic rr, input logic [NA-1:0] ra,
                         input logic hr, input logic [NA-1:0] ha, input logic [1:0] hb);
        logic eh, er;
        @(negedge i_CLK);
        i_run_req = rr; i_run_raddr = ra;
        i_host_req = hr; i_host_raddr = ha; i_host_blk = hb;
        #1;
        eh = hr && (wait_cnt == SM || !rr);
        er = rr && !eh;
        check("run_gnt", o_run_gnt, er);
        check("host_gnt", o_host_gnt, eh);
        if (er) begin
            sb.push_back('{1'b0, run_word(ra), cyc + 2});
            model_raddr = ra;
        end
        if (eh) begin
            sb.push_back('{1'b1, (int'(hb) < NM) ? (NM*BD)'(mem_word(ha, int'(hb))) : '0, cyc + 2});
            model_raddr = ha;
        end
        wait_cnt = (hr && !eh) ? wait_cnt + 1 : 0;
    endtask

    task automatic check_reset_outputs();
        check("rst_raddr", o_mem_raddr, 0);
        check("rst_run_rdata", o_run_rdata, 0);
        check("rst_host_rdata", o_host_rdata, 0);
        check("rst_run_rvalid", o_run_rvalid, 0);
        check("rst_host_rvalid", o_host_rvalid, 0);
        check("rst_busy", o_busy, 0);
    endtask

    // Reset asserted asynchronously mid-cycle; in-flight reads are forgotten by the model.
    task automatic do_reset();
        @(negedge i_CLK);
        i_run_req = 1'b0; i_host_req = 1'b0;
        #2 i_rst_n = 1'b0;
        sb.delete();
        wait_cnt = 0; model_raddr = '0; last_run = '0; last_host = '0;
        #1 check_reset_outputs();
        repeat (2) @(posedge i_CLK);
        #2 i_rst_n = 1'b1;
    endtask

    // Monitor: pops one expectation per rvalid and checks ordering, timing, data, busy and hold.
    initial begin
        exp_t e;
        forever begin
            @(negedge i_CLK);
            if (i_rst_n) begin
                while (sb.size() != 0 && sb[0].due < cyc) begin
                    check("missing_rvalid", 0, 1);
                    void'(sb.pop_front());
                end
                check("busy", o_busy, sb.size() != 0);
                check("mem_raddr", o_mem_raddr, model_raddr);
                check("one_rvalid", o_run_rvalid && o_host_rvalid, 0);
                if (o_run_rvalid || o_host_rvalid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_rvalid", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("owner", o_host_rvalid, e.is_host);
                        check("latency", cyc, e.due);
                        if (e.is_host) begin
                            check("host_rdata", o_host_rdata, e.data);
                            last_host = e.data[BD-1:0];
                        end else begin
                            check("run_rdata", o_run_rdata, e.data);
                            last_run = e.data;
                        end
                    end
                end
                if (!o_run_rvalid) check("run_hold", o_run_rdata, last_run);
                if (!o_host_rvalid) check("host_hold", o_host_rdata, last_host);
            end
        end
    end

    initial begin
        int n_host, first_host;
        #3 check_reset_outputs();
        repeat (2) @(posedge i_CLK);
        #2 i_rst_n = 1'b1;

        // Run-only stream, addresses 0..5 back to back.
        for (int a = 0; a < 6; a++) drive(1'b1, NA'(a), 1'b0, '0, '0);
        drive(1'b0, '0, 1'b0, '0, '0);

        // Host-only read of 0x3A, block 2, then the out-of-range block 3.
        drive(1'b0, '0, 1'b1, 10'h03A, 2'd2);
        drive(1'b0, '0, 1'b1, 10'h011, 2'd3);
        drive(1'b0, '0, 1'b0, '0, '0);

        // Both held high: host granted only at cycles 9, 18, 27 of the hold.
        n_host = 0; first_host = 0;
        for (int i = 1; i <= 3 * (SM + 1); i++) begin
            drive(1'b1, NA'(i), 1'b1, NA'(100 + i), 2'(i % 3));
            if (o_host_gnt) begin
                n_host++;
                if (first_host == 0) first_host = i;
            end
        end
        check("starve_grants", n_host, 3);
        check("starve_first", first_host, SM + 1);

        // Host request withdrawn before it was granted: no transfer.
        drive(1'b1, 10'h005, 1'b1, 10'h3FF, 2'd1);
        drive(1'b0, '0, 1'b0, '0, '0);
        repeat (3) drive(1'b0, '0, 1'b0, '0, '0);

        // Reset one cycle after a grant, then an immediate grant after release.
        drive(1'b1, 10'h155, 1'b0, '0, '0);
        do_reset();
        drive(1'b1, 10'h0AA, 1'b0, '0, '0);
        drive(1'b0, '0, 1'b1, 10'h077, 2'd0);

        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            drive($urandom_range(0, 99) < 60, NA'($urandom), $urandom_range(0, 99) < 55,
                  NA'($urandom), 2'($urandom_range(0, 3)));
        end

        repeat (4) drive(1'b0, '0, 1'b0, '0, '0);
        check("drain", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
